// File: rtl/axi4_lite_mem_slave.sv
// AXI4-Lite slave backed by a single-port-write / single-port-read word memory.
// Write address and write data are captured independently and the memory is
// committed on the edge that completes the later of the two. The read path is a
// two-state FSM with one cycle of latency. Out-of-range words answer SLVERR.
//
//   state  | meaning
//   R_IDLE | arready high, waiting for a read address
//   R_DATA | rvalid high, holding rdata/rresp until rready
module axi4_lite_mem_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [2:0]              awprot,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [2:0]              arprot,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(MEM_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // Word index below MEM_WORDS; byte-offset bits never take part.
  function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] a);
    return (32'(a >> ADDR_LSB) < 32'(MEM_WORDS));
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  logic                  r_ready_en;
  logic                  r_aw_held;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic                  r_w_held;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  r_state_t              r_rstate;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  r_state_t              w_rstate_next;
  logic                  w_arready;
  logic                  w_rvalid;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_cm_addr;
  logic [DATA_WIDTH-1:0] w_cm_data;
  logic [STRB_W-1:0]     w_cm_strb;
  logic                  w_cm_in_range;
  logic [IDX_W-1:0]      w_cm_idx;
  logic                  w_ar_in_range;
  logic [IDX_W-1:0]      w_ar_idx;
  logic                  w_unused_ok;

  assign awready = r_ready_en & ~r_aw_held & ~r_bvalid;
  assign wready  = r_ready_en & ~r_w_held  & ~r_bvalid;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign arready = w_arready;
  assign rvalid  = w_rvalid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

  assign w_aw_hs = awvalid & awready;
  assign w_w_hs  = wvalid & wready;
  assign w_ar_hs = arvalid & w_arready;

  // A handshake on this edge stands in for a hold that has not been captured yet.
  assign w_commit      = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
  assign w_cm_addr     = r_aw_held ? r_aw_addr : awaddr;
  assign w_cm_data     = r_w_held ? r_wdata : wdata;
  assign w_cm_strb     = r_w_held ? r_wstrb : wstrb;
  assign w_cm_in_range = f_in_range(w_cm_addr);
  assign w_cm_idx      = w_cm_addr[ADDR_LSB +: IDX_W];

  assign w_ar_in_range = f_in_range(araddr);
  assign w_ar_idx      = araddr[ADDR_LSB +: IDX_W];

  assign w_unused_ok = ^{awprot, arprot, awaddr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};

  // Ready outputs stay low through reset and rise on the first edge after release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_ready_en <= 1'b0;
    else          r_ready_en <= 1'b1;
  end

  // Write channel holds and write response.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_aw_held <= 1'b0;
      r_aw_addr <= '0;
      r_w_held  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b1;
      r_bresp   <= w_cm_in_range ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= wdata;
        r_wstrb  <= wstrb;
      end
      if (r_bvalid && bready) r_bvalid <= 1'b0;
    end
  end

  // Memory write port: byte-lane merge, contents deliberately not reset.
  always_ff @(posedge aclk) begin
    if (w_commit && w_cm_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_cm_strb[b]) r_mem[w_cm_idx][b*8 +: 8] <= w_cm_data[b*8 +: 8];
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_rstate <= R_IDLE;
    else          r_rstate <= w_rstate_next;
  end

  // Read FSM next state and channel handshake outputs.
  always_comb begin
    w_rstate_next = r_rstate;
    w_arready     = 1'b0;
    w_rvalid      = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        w_arready = r_ready_en;
        if (arvalid && r_ready_en) w_rstate_next = R_DATA;
      end
      R_DATA: begin
        w_rvalid = 1'b1;
        if (rready) w_rstate_next = R_IDLE;
      end
      default: w_rstate_next = R_IDLE;
    endcase
  end

  // Read sample on the AR handshake; the old word wins over a same-edge write.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_ar_in_range ? r_mem[w_ar_idx] : '0;
      r_rresp <= w_ar_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

endmodule
